// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared MSDAP constants and receiver state type
package msdap_pkg;

    localparam int WORD_W      = 16;
    localparam int ZERO_RUN    = 800;
    localparam int ZCNT_W      = 10;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/msdap_sync_bit.sv
// rtl/msdap_sync_bit.sv - multi-stage single-bit synchroniser into the Sclk domain
module msdap_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/msdap_serial_rx.sv
// rtl/msdap_serial_rx.sv - oversampling stereo serial receiver with framing check and zero-run detect
module msdap_serial_rx #(
    parameter int WORD_W      = msdap_pkg::WORD_W,
    parameter int SYNC_STAGES = msdap_pkg::SYNC_STAGES,
    parameter int ZERO_RUN    = msdap_pkg::ZERO_RUN,
    parameter int ZCNT_W      = msdap_pkg::ZCNT_W
) (
    input  logic              Sclk,
    input  logic              Reset,
    input  logic              Dclk,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    input  logic              rx_en,
    output logic [WORD_W-1:0] data_l,
    output logic [WORD_W-1:0] data_r,
    output logic              word_valid,
    output logic              frame_err,
    output logic              zero_run,
    output logic              busy
);

    import msdap_pkg::rx_state_t;
    import msdap_pkg::IDLE;
    import msdap_pkg::SHIFT;

    localparam int CNT_W = $clog2(WORD_W);

    logic dclk_s, frame_s, in_l_s, in_r_s;
    logic dclk_d;
    logic strike;

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] sh_l, sh_r;
    logic [WORD_W-1:0] nxt_l, nxt_r;
    logic [ZCNT_W-1:0] zc, zc_nxt;

    msdap_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dclk  (.clk(Sclk), .rst_n(Reset), .d(Dclk),   .q(dclk_s));
    msdap_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_frame (.clk(Sclk), .rst_n(Reset), .d(Frame),  .q(frame_s));
    msdap_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_inl   (.clk(Sclk), .rst_n(Reset), .d(InputL), .q(in_l_s));
    msdap_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_inr   (.clk(Sclk), .rst_n(Reset), .d(InputR), .q(in_r_s));

    // Dclk falling edge: the source drives on the rising edge, so data is mid-eye here
    assign strike = ~dclk_s & dclk_d;

    // LSB arrives first; after WORD_W right-shifts bit 0 sits at position 0
    assign nxt_l = {in_l_s, sh_l[WORD_W-1:1]};
    assign nxt_r = {in_r_s, sh_r[WORD_W-1:1]};

    assign busy = (state == SHIFT);

    always_comb begin
        zc_nxt = zc;
        if (word_valid) begin
            if (data_l == '0 && data_r == '0) begin
                zc_nxt = (zc == ZCNT_W'(ZERO_RUN)) ? zc : zc + ZCNT_W'(1);
            end else begin
                zc_nxt = '0;
            end
        end
    end

    always_ff @(posedge Sclk or negedge Reset) begin
        if (!Reset) begin
            dclk_d     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            sh_l       <= '0;
            sh_r       <= '0;
            data_l     <= '0;
            data_r     <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            zc         <= '0;
            zero_run   <= 1'b0;
        end else begin
            dclk_d     <= dclk_s;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            zc         <= zc_nxt;
            zero_run   <= (zc_nxt == ZCNT_W'(ZERO_RUN));
            if (strike) begin
                case (state)
                    IDLE: begin
                        if (frame_s && rx_en) begin
                            sh_l  <= nxt_l;
                            sh_r  <= nxt_r;
                            cnt   <= CNT_W'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        sh_l <= nxt_l;
                        sh_r <= nxt_r;
                        // A Frame mid-word restarts the word with this strike's bit as bit 0
                        if (frame_s && cnt != '0) begin
                            frame_err <= 1'b1;
                            cnt       <= CNT_W'(1);
                        end else if (cnt == CNT_W'(WORD_W - 1)) begin
                            data_l     <= nxt_l;
                            data_r     <= nxt_r;
                            word_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msdap_serial_rx.sv
// tb/tb_msdap_serial_rx.sv - randomized scoreboard bench for msdap_serial_rx
module tb_msdap_serial_rx;

    localparam int ZR  = 12;
    localparam int ZCW = 4;

    logic        Sclk = 1'b0;
    logic        Dclk = 1'b0;
    logic        Reset = 1'b0;
    logic        Frame = 1'b0;
    logic        InputL = 1'b0;
    logic        InputR = 1'b0;
    logic        rx_en = 1'b0;
    logic [15:0] data_l, data_r;
    logic        word_valid, frame_err, zero_run, busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          got = 0;
    int          ferr_seen = 0;
    int          ferr_exp = 0;
    int          run = 0;
    bit          pend_zr = 1'b0;

    msdap_serial_rx #(
        .WORD_W(16), .SYNC_STAGES(2), .ZERO_RUN(ZR), .ZCNT_W(ZCW)
    ) dut (
        .Sclk(Sclk), .Reset(Reset), .Dclk(Dclk), .Frame(Frame),
        .InputL(InputL), .InputR(InputR), .rx_en(rx_en),
        .data_l(data_l), .data_r(data_r), .word_valid(word_valid),
        .frame_err(frame_err), .zero_run(zero_run), .busy(busy)
    );

    always #18.601ns Sclk = ~Sclk;

    initial begin
        repeat ($urandom_range(0, 1300)) #1ns;
        forever #651.04ns Dclk = ~Dclk;
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop expected pairs on word_valid; zero_run follows a run-length model one cycle later
    always @(negedge Sclk) begin
        if (!Reset) begin
            run     = 0;
            pend_zr = 1'b0;
        end else begin
            if (pend_zr) begin
                check(zero_run == (run >= ZR), "zero_run", 32'(zero_run), 32'(run >= ZR));
                pend_zr = 1'b0;
            end
            if (word_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", {data_l, data_r}, 32'h0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check({data_l, data_r} == e, "word", {data_l, data_r}, e);
                    if (e == 32'h0) run++;
                    else run = 0;
                    pend_zr = 1'b1;
                end
            end
            if (frame_err) ferr_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Dclk);
            Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] l, input logic [15:0] r, input int nbits, input int drop_at);
        for (int b = 0; b < nbits; b++) begin
            @(posedge Dclk);
            if (b == drop_at) rx_en = 1'b0;
            Frame = (b == 0); InputL = l[b]; InputR = r[b];
        end
    endtask

    task automatic send_exp(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back({l, r});
        send_word(l, r, 16, -1);
    endtask

    task automatic drain(input string name, input int exp_got);
        idle(3);
        check(exp_q.size() == 0, name, 32'(exp_q.size()), 32'h0);
        check(got == exp_got, "word_count", 32'(got), 32'(exp_got));
        check(ferr_seen == ferr_exp, "frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
    endtask

    task automatic check_zero_outputs(input string tag);
        check(data_l == 16'h0, {tag, "_data_l"}, 32'(data_l), 32'h0);
        check(data_r == 16'h0, {tag, "_data_r"}, 32'(data_r), 32'h0);
        check(word_valid == 1'b0, {tag, "_word_valid"}, 32'(word_valid), 32'h0);
        check(frame_err == 1'b0, {tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check(zero_run == 1'b0, {tag, "_zero_run"}, 32'(zero_run), 32'h0);
        check(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_got;
        logic [15:0] a, b;
        exp_got = 0;
        rx_en = 1'b1;
        repeat (5) @(negedge Sclk);
        check_zero_outputs("reset");
        @(negedge Sclk) Reset = 1'b1;
        idle(2);

        send_exp(16'h1234, 16'hFEDC);
        exp_got += 1;
        drain("single_word", exp_got);

        for (int i = 0; i < 20; i++) send_exp(16'(i), ~16'(i));
        exp_got += 20;
        drain("stream", exp_got);

        for (int i = 0; i < 8; i++) begin
            send_exp(16'($urandom), 16'($urandom));
            idle($urandom_range(0, 2));
        end
        exp_got += 8;
        drain("random_stream", exp_got);

        ferr_exp++;
        send_word(16'hFFFF, 16'hFFFF, 7, -1);
        send_exp(16'hA5A5, 16'h5A5A);
        exp_got += 1;
        drain("frame_error", exp_got);

        for (int i = 0; i < 4; i++) begin
            ferr_exp++;
            send_word(16'($urandom), 16'($urandom), $urandom_range(1, 15), -1);
            send_exp(16'($urandom), 16'($urandom));
        end
        exp_got += 4;
        drain("random_frame_error", exp_got);

        rx_en = 1'b0;
        send_word(16'h1111, 16'h2222, 16, -1);
        send_word(16'h3333, 16'h4444, 16, -1);
        idle(2);
        rx_en = 1'b1;
        idle(1);
        a = 16'($urandom) | 16'h8000;
        b = 16'($urandom);
        exp_q.push_back({a, b});
        send_word(a, b, 16, 5);
        send_word(16'h5555, 16'h6666, 16, -1);
        exp_got += 1;
        drain("gate", exp_got);
        rx_en = 1'b1;

        for (int i = 0; i < ZR + 6; i++) send_exp(16'h0, 16'h0);
        send_exp(16'h0001, 16'h0000);
        exp_got += ZR + 7;
        drain("sleep", exp_got);
        check(zero_run == 1'b0, "sleep_exit", 32'(zero_run), 32'h0);

        for (int i = 0; i < ZR; i++) send_exp(16'h0, 16'h0);
        exp_got += ZR;
        drain("sleep_again", exp_got);
        check(zero_run == 1'b1, "sleep_level", 32'(zero_run), 32'h1);

        send_word(16'hBEEF, 16'hCAFE, 9, -1);
        @(posedge Dclk);
        check(busy == 1'b1, "busy_mid_word", 32'(busy), 32'h1);
        Reset = 1'b0; Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
        #2ns;
        check_zero_outputs("async_reset");
        @(negedge Sclk) Reset = 1'b1;
        idle(2);
        send_exp(16'h0F0F, 16'hF0F0);
        exp_got += 1;
        drain("after_reset", exp_got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
